// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: timed arithmetic-quiz round controller.
// Operands and the operator come from a free-running LFSR. The player names
// the hidden operator with push buttons. The block keeps BCD score, lives and
// the round count, and drives raw values for the board's display logic.
module quiz_round_ctrl #(
  parameter int          MAX_OPERAND = 9,
  parameter int          TICK_DIV    = 65536,
  parameter int          ROUND_TICKS = 30,
  parameter int          LIVES       = 3,
  parameter int          ROUNDS      = 20,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] answer,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [7:0] result,
  output logic [1:0] op,
  output logic [5:0] time_left,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [2:0] lives,
  output logic       round_active,
  output logic       game_over,
  output logic       correct_pulse,
  output logic       wrong_pulse
);

  typedef enum logic [1:0] {IDLE, GEN, WAIT, OVER} state_t;

  localparam int         PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] MAXV = 4'(MAX_OPERAND);
  localparam logic [3:0] RED  = 4'(MAX_OPERAND + 1);

  state_t          state, next_state;
  logic [15:0]     lfsr;
  logic [3:0]      answer_d;
  logic [PW-1:0]   prescale;
  logic [7:0]      round_cnt;

  logic [3:0]      a_raw, b_raw, a_red, b_red, n1_gen, n2_gen;
  logic [1:0]      op_gen;
  logic [7:0]      res_gen;

  logic [3:0]      ans_edge;
  logic            multi, add_ok, sub_ok, mul_ok;
  logic            judged, hit, miss, start_game;
  logic [7:0]      round_inc;

  // Operand candidates derived from the current LFSR value
  always_comb begin
    a_raw = lfsr[7:4];
    b_raw = lfsr[11:8];
    a_red = (a_raw > MAXV) ? a_raw - RED : a_raw;
    b_red = (b_raw > MAXV) ? b_raw - RED : b_raw;
    if (a_red >= b_red) begin
      n1_gen = a_red;
      n2_gen = b_red;
    end else begin
      n1_gen = b_red;
      n2_gen = a_red;
    end
    op_gen = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
    case (op_gen)
      2'd0:    res_gen = {4'b0, n1_gen} + {4'b0, n2_gen};
      2'd1:    res_gen = {4'b0, n1_gen - n2_gen};
      default: res_gen = {4'b0, n1_gen} * {4'b0, n2_gen};
    endcase
  end

  // Button edges and which operators reproduce the displayed result
  always_comb begin
    ans_edge  = answer & ~answer_d;
    multi     = (ans_edge & (ans_edge - 4'd1)) != 4'd0;
    add_ok    = ({4'b0, num1} + {4'b0, num2}) == result;
    sub_ok    = {4'b0, num1 - num2} == result;
    mul_ok    = ({4'b0, num1} * {4'b0, num2}) == result;
    round_inc = round_cnt + 8'd1;
  end

  // Game FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state, judging and state-decoded outputs
  always_comb begin
    next_state   = state;
    judged       = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    start_game   = 1'b0;
    round_active = (state == WAIT);
    game_over    = (state == OVER);
    case (state)
      IDLE, OVER: begin
        if (start) begin
          start_game = 1'b1;
          next_state = GEN;
        end
      end
      GEN: next_state = WAIT;
      WAIT: begin
        // An edge outranks a simultaneous timeout
        if (ans_edge != 4'd0) begin
          judged = 1'b1;
          if (multi)
            miss = 1'b1;
          else if (ans_edge[3])
            miss = 1'b0;
          else if ((ans_edge[0] && add_ok) || (ans_edge[1] && sub_ok) ||
                   (ans_edge[2] && mul_ok))
            hit = 1'b1;
          else
            miss = 1'b1;
        end else if (time_left == 6'd0) begin
          judged = 1'b1;
          miss   = 1'b1;
        end
        if (judged) begin
          if ((miss && lives == 3'd1) || round_inc == 8'(ROUNDS))
            next_state = OVER;
          else
            next_state = GEN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: LFSR, edge history, operands, timer, score, lives, rounds
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr          <= SEED;
      answer_d      <= '0;
      prescale      <= '0;
      round_cnt     <= '0;
      num1          <= '0;
      num2          <= '0;
      result        <= '0;
      op            <= '0;
      time_left     <= '0;
      score_tens    <= '0;
      score_ones    <= '0;
      lives         <= 3'(LIVES);
      correct_pulse <= 1'b0;
      wrong_pulse   <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      answer_d      <= answer;
      correct_pulse <= hit;
      wrong_pulse   <= miss;
      if (start_game) begin
        score_tens <= '0;
        score_ones <= '0;
        lives      <= 3'(LIVES);
        round_cnt  <= '0;
      end
      if (state == GEN) begin
        num1      <= n1_gen;
        num2      <= n2_gen;
        op        <= op_gen;
        result    <= res_gen;
        time_left <= 6'(ROUND_TICKS);
        prescale  <= '0;
      end
      if (state == WAIT) begin
        if (judged) begin
          round_cnt <= round_inc;
          if (hit) begin
            if (score_ones == 4'd9) begin
              if (score_tens != 4'd9) begin
                score_tens <= score_tens + 4'd1;
                score_ones <= '0;
              end
            end else begin
              score_ones <= score_ones + 4'd1;
            end
          end
          if (miss) lives <= lives - 3'd1;
        end else if (prescale == PW'(TICK_DIV - 1)) begin
          prescale  <= '0;
          time_left <= time_left - 6'd1;
        end else begin
          prescale <= prescale + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl. Expected operands are predicted
// from an LFSR reference model when a round is generated and queued; they are
// popped and compared once the round's WAIT state is visible.
module tb_quiz_round_ctrl;

  localparam int          MAXOP   = 9;
  localparam int          TDIV    = 4;
  localparam int          RTICKS  = 3;
  localparam int          NLIVES  = 3;
  localparam int          NROUNDS = 200;
  localparam logic [15:0] SEED_V  = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] answer;
  logic [3:0] num1, num2, score_tens, score_ones;
  logic [7:0] result;
  logic [1:0] op;
  logic [5:0] time_left;
  logic [2:0] lives;
  logic       round_active, game_over, correct_pulse, wrong_pulse;

  quiz_round_ctrl #(
    .MAX_OPERAND(MAXOP),
    .TICK_DIV   (TDIV),
    .ROUND_TICKS(RTICKS),
    .LIVES      (NLIVES),
    .ROUNDS     (NROUNDS),
    .SEED       (SEED_V)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .answer       (answer),
    .num1         (num1),
    .num2         (num2),
    .result       (result),
    .op           (op),
    .time_left    (time_left),
    .score_tens   (score_tens),
    .score_ones   (score_ones),
    .lives        (lives),
    .round_active (round_active),
    .game_over    (game_over),
    .correct_pulse(correct_pulse),
    .wrong_pulse  (wrong_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n1;
    int n2;
    int op;
    int res;
  } opnd_t;

  opnd_t       exp_q[$];
  opnd_t       cur;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          sc      = 0;
  int          lv      = NLIVES;
  logic [15:0] m_lfsr;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED_V;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int apply(int k, int x, int y);
    case (k)
      0:       return x + y;
      1:       return x - y;
      default: return x * y;
    endcase
  endfunction

  function automatic opnd_t predict(logic [15:0] l);
    opnd_t r;
    int a, b;
    a = int'(l[7:4]);
    b = int'(l[11:8]);
    if (a > MAXOP) a = a - (MAXOP + 1);
    if (b > MAXOP) b = b - (MAXOP + 1);
    r.n1  = (a > b) ? a : b;
    r.n2  = (a > b) ? b : a;
    r.op  = (l[1:0] == 2'd3) ? 0 : int'(l[1:0]);
    r.res = apply(r.op, r.n1, r.n2);
    return r;
  endfunction

  // Called in the GEN cycle: the LFSR value now is what gets registered
  task automatic push_gen();
    exp_q.push_back(predict(m_lfsr));
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; answer = 4'd0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (round_active !== 1'b0 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: active=%b over=%b, want 0 0", round_active, game_over);
    end
    n_tests++;
    if (lives !== 3'(NLIVES) || score_tens !== 4'd0 || score_ones !== 4'd0) begin
      n_fail++; $display("FAIL reset_score: lives=%0d score=%0d%0d, want %0d 00", lives, score_tens, score_ones, NLIVES);
    end
    n_tests++;
    if (num1 !== 4'd0 || num2 !== 4'd0 || result !== 8'd0 || op !== 2'd0 || time_left !== 6'd0) begin
      n_fail++; $display("FAIL reset_display: %0d %0d %0d op%0d t%0d, want all 0", num1, num2, result, op, time_left);
    end
    n_tests++;
    if (correct_pulse !== 1'b0 || wrong_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: c=%b w=%b, want 0 0", correct_pulse, wrong_pulse);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (round_active !== 1'b0 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: active=%b over=%b, want 0 0", round_active, game_over);
    end
  endtask

  task automatic test_correct();
    start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (round_active !== 1'b0 || game_over !== 1'b0 || lives !== 3'(NLIVES)) begin
      n_fail++; $display("FAIL start_gen: active=%b over=%b lives=%0d, want 0 0 %0d", round_active, game_over, lives, NLIVES);
    end
    push_gen();
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (round_active !== 1'b1 || time_left !== 6'(RTICKS)) begin
      n_fail++; $display("FAIL start_wait: active=%b t=%0d, want 1 %0d", round_active, time_left, RTICKS);
    end
    cur = exp_q.pop_front();
    n_tests++;
    if (num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || op !== 2'(cur.op) || result !== 8'(cur.res)) begin
      n_fail++; $display("FAIL operands_first: got %0d %0d op%0d =%0d, want %0d %0d op%0d =%0d",
                         num1, num2, op, result, cur.n1, cur.n2, cur.op, cur.res);
    end
    answer = 4'(1 << cur.op);
    @(negedge clk);
    sc = 1;
    n_tests++;
    if (correct_pulse !== 1'b1 || wrong_pulse !== 1'b0 || round_active !== 1'b0) begin
      n_fail++; $display("FAIL correct_pulse: c=%b w=%b active=%b, want 1 0 0", correct_pulse, wrong_pulse, round_active);
    end
    n_tests++;
    if (score_tens !== 4'd0 || score_ones !== 4'd1) begin
      n_fail++; $display("FAIL correct_score: score=%0d%0d, want 01", score_tens, score_ones);
    end
    push_gen();
    answer = 4'd0;
    @(negedge clk);
    n_tests++;
    if (correct_pulse !== 1'b0 || round_active !== 1'b1) begin
      n_fail++; $display("FAIL pulse_width: c=%b active=%b, want 0 1", correct_pulse, round_active);
    end
    cur = exp_q.pop_front();
    n_tests++;
    if (num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || op !== 2'(cur.op) || result !== 8'(cur.res)) begin
      n_fail++; $display("FAIL operands_next: got %0d %0d op%0d =%0d, want %0d %0d op%0d =%0d",
                         num1, num2, op, result, cur.n1, cur.n2, cur.op, cur.res);
    end
  endtask

  // Hold the correct operator button for 50 cycles; pass presses keep rounds moving
  task automatic test_hold();
    int k;
    k = cur.op;
    answer = 4'(1 << k);
    @(negedge clk);
    sc++;
    n_tests++;
    if (correct_pulse !== 1'b1 || score_ones !== 4'(sc % 10)) begin
      n_fail++; $display("FAIL hold_first: c=%b ones=%0d, want 1 %0d", correct_pulse, score_ones, sc % 10);
    end
    push_gen();
    @(negedge clk);
    cur = exp_q.pop_front();
    for (int i = 0; i < 24; i++) begin
      answer = 4'(1 << k) | 4'b1000;
      @(negedge clk);
      n_tests++;
      if (correct_pulse !== 1'b0 || wrong_pulse !== 1'b0 || round_active !== 1'b0) begin
        n_fail++; $display("FAIL hold_retrigger: iter %0d c=%b w=%b active=%b, want 0 0 0", i, correct_pulse, wrong_pulse, round_active);
      end
      push_gen();
      answer = 4'(1 << k);
      @(negedge clk);
      cur = exp_q.pop_front();
      n_tests++;
      if (num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || op !== 2'(cur.op) || result !== 8'(cur.res)) begin
        n_fail++; $display("FAIL operands_hold: got %0d %0d op%0d =%0d, want %0d %0d op%0d =%0d",
                           num1, num2, op, result, cur.n1, cur.n2, cur.op, cur.res);
      end
    end
    answer = 4'd0;
    n_tests++;
    if (score_ones !== 4'(sc % 10) || lives !== 3'(lv)) begin
      n_fail++; $display("FAIL hold_end: ones=%0d lives=%0d, want %0d %0d", score_ones, lives, sc % 10, lv);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 13; i++) begin
      n_tests++;
      if (time_left !== 6'(RTICKS - i / TDIV) || round_active !== 1'b1 || wrong_pulse !== 1'b0) begin
        n_fail++; $display("FAIL timer_step: cycle %0d t=%0d active=%b w=%b, want %0d 1 0",
                           i, time_left, round_active, wrong_pulse, RTICKS - i / TDIV);
      end
      @(negedge clk);
    end
    lv--;
    n_tests++;
    if (wrong_pulse !== 1'b1 || correct_pulse !== 1'b0 || lives !== 3'(lv) || round_active !== 1'b0) begin
      n_fail++; $display("FAIL timeout: w=%b c=%b lives=%0d active=%b, want 1 0 %0d 0", wrong_pulse, correct_pulse, lives, lv, round_active);
    end
    push_gen();
    @(negedge clk);
    cur = exp_q.pop_front();
    n_tests++;
    if (num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || op !== 2'(cur.op) || result !== 8'(cur.res)) begin
      n_fail++; $display("FAIL operands_timeout: got %0d %0d op%0d =%0d, want %0d %0d op%0d =%0d",
                         num1, num2, op, result, cur.n1, cur.n2, cur.op, cur.res);
    end
  endtask

  task automatic test_multi();
    answer = 4'b0101;
    @(negedge clk);
    lv--;
    n_tests++;
    if (wrong_pulse !== 1'b1 || correct_pulse !== 1'b0 || lives !== 3'(lv)) begin
      n_fail++; $display("FAIL multi_edge: w=%b c=%b lives=%0d, want 1 0 %0d", wrong_pulse, correct_pulse, lives, lv);
    end
    push_gen();
    answer = 4'd0;
    @(negedge clk);
    cur = exp_q.pop_front();
  endtask

  task automatic test_game_over();
    logic [3:0] mask;
    mask = 4'b0011;
    for (int k = 2; k >= 0; k--)
      if (apply(k, cur.n1, cur.n2) != cur.res) mask = 4'(1 << k);
    answer = mask;
    @(negedge clk);
    lv--;
    n_tests++;
    if (wrong_pulse !== 1'b1 || game_over !== 1'b1 || round_active !== 1'b0 || lives !== 3'(lv)) begin
      n_fail++; $display("FAIL game_over: w=%b over=%b active=%b lives=%0d, want 1 1 0 %0d", wrong_pulse, game_over, round_active, lives, lv);
    end
    answer = 4'd0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (game_over !== 1'b1 || num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || result !== 8'(cur.res) ||
        time_left !== 6'(RTICKS) || score_ones !== 4'(sc % 10) || wrong_pulse !== 1'b0) begin
      n_fail++; $display("FAIL over_frozen: over=%b %0d %0d =%0d t=%0d ones=%0d w=%b, want 1 %0d %0d =%0d t=%0d ones=%0d w=0",
                         game_over, num1, num2, result, time_left, score_ones, wrong_pulse,
                         cur.n1, cur.n2, cur.res, RTICKS, sc % 10);
    end
    start = 1'b1;
    @(negedge clk);
    sc = 0;
    lv = NLIVES;
    n_tests++;
    if (game_over !== 1'b0 || round_active !== 1'b0 || score_tens !== 4'd0 || score_ones !== 4'd0 || lives !== 3'(lv)) begin
      n_fail++; $display("FAIL restart_gen: over=%b active=%b score=%0d%0d lives=%0d, want 0 0 00 %0d",
                         game_over, round_active, score_tens, score_ones, lives, lv);
    end
    push_gen();
    start = 1'b0;
    @(negedge clk);
    cur = exp_q.pop_front();
    n_tests++;
    if (round_active !== 1'b1 || num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || result !== 8'(cur.res)) begin
      n_fail++; $display("FAIL restart_wait: active=%b %0d %0d =%0d, want 1 %0d %0d =%0d",
                         round_active, num1, num2, result, cur.n1, cur.n2, cur.res);
    end
  endtask

  // 101 correct answers: crosses 09->10 and saturates at 99
  task automatic test_score_sat();
    for (int i = 0; i < 101; i++) begin
      answer = 4'(1 << cur.op);
      @(negedge clk);
      sc = (sc < 99) ? sc + 1 : 99;
      n_tests++;
      if (correct_pulse !== 1'b1 || score_tens !== 4'(sc / 10) || score_ones !== 4'(sc % 10)) begin
        n_fail++; $display("FAIL score_bcd: answer %0d c=%b score=%0d%0d, want 1 %0d%0d",
                           i, correct_pulse, score_tens, score_ones, sc / 10, sc % 10);
      end
      push_gen();
      answer = 4'd0;
      @(negedge clk);
      cur = exp_q.pop_front();
      n_tests++;
      if (num1 !== 4'(cur.n1) || num2 !== 4'(cur.n2) || op !== 2'(cur.op) || result !== 8'(cur.res)) begin
        n_fail++; $display("FAIL operands_score: got %0d %0d op%0d =%0d, want %0d %0d op%0d =%0d",
                           num1, num2, op, result, cur.n1, cur.n2, cur.op, cur.res);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (round_active !== 1'b0 || game_over !== 1'b0 || lives !== 3'(NLIVES) || score_tens !== 4'd0 ||
        score_ones !== 4'd0 || num1 !== 4'd0 || time_left !== 6'd0) begin
      n_fail++; $display("FAIL reset_mid: active=%b over=%b lives=%0d score=%0d%0d n1=%0d t=%0d, want 0 0 %0d 00 0 0",
                         round_active, game_over, lives, score_tens, score_ones, num1, time_left, NLIVES);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (round_active !== 1'b0 || correct_pulse !== 1'b0 || wrong_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: active=%b c=%b w=%b, want 0 0 0", round_active, correct_pulse, wrong_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_hold();
    test_timeout();
    test_multi();
    test_game_over();
    test_score_sat();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
